// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges stage stall requests, sequences exception/ERET
// flushes with a one-cycle bubble hold, and tracks a stall watchdog and stall-cycle counter.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h00000020,
  parameter int unsigned MAX_STALL  = 64,
  parameter logic [31:0] ERET_CODE  = 32'h0000000e
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] perf_stall_cycles
);

  typedef enum logic {RUN, FLUSH_HOLD} state_t;

  localparam logic [15:0] CONSEC_MAX = 16'(MAX_STALL);
  localparam logic [15:0] CONSEC_TRIP = 16'(MAX_STALL - 1);

  state_t      state;
  logic [15:0] consec;
  logic        stalled;

  // Zero-latency arbitration so the stage registers react in the same cycle.
  always_comb begin
    stall  = 6'b000000;
    flush  = 1'b0;
    new_pc = 32'h00000000;
    if (!rst && state == RUN) begin
      if (excepttype_i != 32'h00000000) begin
        flush  = 1'b1;
        new_pc = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
      end else if (stallreq_mem) begin
        stall = 6'b011111;
      end else if (stallreq_ex) begin
        stall = 6'b001111;
      end else if (stallreq_id) begin
        stall = 6'b000111;
      end
    end
  end

  assign stalled = (stall != 6'b000000);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= RUN;
      consec            <= 16'd0;
      stall_timeout     <= 1'b0;
      perf_stall_cycles <= 32'h00000000;
    end else begin
      // A flush always lands in FLUSH_HOLD; the hold state always returns to RUN.
      state <= flush ? FLUSH_HOLD : RUN;
      if (!stalled) begin
        consec <= 16'd0;
      end else if (consec != CONSEC_MAX) begin
        consec <= consec + 16'd1;
      end
      if (stalled && consec == CONSEC_TRIP) begin
        stall_timeout <= 1'b1;
      end
      if (stalled) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed, table-driven bench for pipe_ctrl (watchdog threshold shortened to 4).
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] perf_stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_ctrl #(
    .EXC_VECTOR(32'h00000020),
    .MAX_STALL (4),
    .ERET_CODE (32'h0000000e)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_id      (stallreq_id),
    .stallreq_ex      (stallreq_ex),
    .stallreq_mem     (stallreq_mem),
    .excepttype_i     (excepttype_i),
    .cp0_epc_i        (cp0_epc_i),
    .stall            (stall),
    .flush            (flush),
    .new_pc           (new_pc),
    .stall_timeout    (stall_timeout),
    .perf_stall_cycles(perf_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic        ex;
    logic        mem;
    logic [31:0] exc;
    logic [31:0] epc;
    logic [5:0]  exp_stall;
    logic        exp_flush;
    logic [31:0] exp_pc;
    logic [31:0] exp_perf;
    logic        exp_to;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic id, input logic ex, input logic mem, input logic [31:0] exc,
                     input logic [31:0] epc, input logic [5:0] es, input logic ef,
                     input logic [31:0] ep, input logic [31:0] eperf, input logic eto);
    vec_t v;
    v.id = id; v.ex = ex; v.mem = mem; v.exc = exc; v.epc = epc;
    v.exp_stall = es; v.exp_flush = ef; v.exp_pc = ep; v.exp_perf = eperf; v.exp_to = eto;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic id, input logic ex, input logic mem,
                       input logic [31:0] exc, input logic [31:0] epc);
    rst = r; stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
    excepttype_i = exc; cp0_epc_i = epc;
  endtask

  initial begin
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h8, 32'h0);

    // Each row: inputs for one cycle, expected outputs and registered state before its edge.
    add(1, 0, 0, 32'h0, 32'h0, 6'b000111, 0, 32'h0, 32'd0, 0);
    add(1, 1, 0, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 32'd1, 0);
    add(1, 1, 1, 32'h0, 32'h0, 6'b011111, 0, 32'h0, 32'd2, 0);
    add(0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 32'd3, 0);
    add(0, 1, 0, 32'h8, 32'h0, 6'b000000, 1, 32'h20, 32'd3, 0);
    add(0, 0, 1, 32'h8, 32'h0, 6'b000000, 0, 32'h0, 32'd3, 0);
    add(0, 0, 1, 32'h0, 32'h0, 6'b011111, 0, 32'h0, 32'd3, 0);
    add(0, 0, 0, 32'he, 32'hBFC00100, 6'b000000, 1, 32'hBFC00100, 32'd4, 0);
    add(1, 1, 1, 32'he, 32'hBFC00100, 6'b000000, 0, 32'h0, 32'd4, 0);
    add(0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 32'd4, 0);
    add(0, 1, 0, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 32'd4, 0);
    add(0, 1, 0, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 32'd5, 0);
    add(0, 1, 0, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 32'd6, 0);
    add(0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 32'd7, 0);
    add(0, 1, 0, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 32'd7, 0);
    add(0, 1, 0, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 32'd8, 0);
    add(0, 1, 0, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 32'd9, 0);
    add(0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 32'd10, 0);
    add(0, 1, 0, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 32'd10, 0);
    add(0, 1, 0, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 32'd11, 0);
    add(0, 1, 0, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 32'd12, 0);
    add(0, 1, 0, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 32'd13, 0);
    add(0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 32'd14, 1);
    add(0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 32'd14, 1);
    add(0, 1, 0, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 32'd14, 1);
    add(0, 1, 0, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 32'd15, 1);
    add(0, 1, 0, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 32'd16, 1);
    add(0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 32'd17, 1);

    // Reset held two cycles with every request active.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check("reset_stall", {26'h0, stall}, 32'h0);
      check("reset_flush", {31'h0, flush}, 32'h0);
      check("reset_new_pc", new_pc, 32'h0);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("reset_perf", perf_stall_cycles, 32'h0);
    check("reset_timeout", {31'h0, stall_timeout}, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(1'b0, vecs[i].id, vecs[i].ex, vecs[i].mem, vecs[i].exc, vecs[i].epc);
      #1;
      check($sformatf("v%0d_stall", i), {26'h0, stall}, {26'h0, vecs[i].exp_stall});
      check($sformatf("v%0d_flush", i), {31'h0, flush}, {31'h0, vecs[i].exp_flush});
      check($sformatf("v%0d_new_pc", i), new_pc, vecs[i].exp_pc);
      check($sformatf("v%0d_perf", i), perf_stall_cycles, vecs[i].exp_perf);
      check($sformatf("v%0d_timeout", i), {31'h0, stall_timeout}, {31'h0, vecs[i].exp_to});
      @(negedge clk);
    end

    // Counter wrap: preload all-ones, then one stalled cycle.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    force dut.perf_stall_cycles = 32'hFFFFFFFF;
    #1;
    release dut.perf_stall_cycles;
    #1;
    check("wrap_preload", perf_stall_cycles, 32'hFFFFFFFF);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("wrap_zero", perf_stall_cycles, 32'h0);

    // Reset asserted while in FLUSH_HOLD must return straight to RUN.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
    #1;
    check("rstflush_flush", {31'h0, flush}, 32'h1);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("rstflush_stall_in_rst", {26'h0, stall}, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("rstflush_run_stall", {26'h0, stall}, 32'h00000007);
    check("rstflush_flush_low", {31'h0, flush}, 32'h0);
    check("rstflush_new_pc", new_pc, 32'h0);
    check("rstflush_timeout", {31'h0, stall_timeout}, 32'h0);
    check("rstflush_perf", perf_stall_cycles, 32'h0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
